// File: rtl/operand2_stage_pkg.sv
// Shared types for the operand-2 stage.
//   state_t   : stage FSM states (EMPTY / RS_FETCH / FULL)
//   SH_*      : shifter type encodings carried on the sh output
//   src2_t    : decoded Src2 field produced by src2_decode
//   rs_shamt  : clamps the low byte of Rs to a 5-bit shift amount plus overflow flag
package operand2_stage_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    RS_FETCH = 2'd1,
    FULL     = 2'd2
  } state_t;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef struct packed {
    logic       use_imm;   // operand is the 8-bit immediate, not Rm
    logic [7:0] imm8;
    logic [1:0] sh;
    logic [4:0] shamt5;    // meaningless when needs_rs is set
    logic       needs_rs;  // shift amount comes from Rs
    logic [3:0] rs_addr;
  } src2_t;

  // {shamt_big, shamt5}: amounts of 32..255 saturate to 31 and raise the flag
  // so the shifter can apply the full-width result.
  function automatic logic [5:0] rs_shamt(input logic [7:0] rs_lo);
    if (rs_lo[7:5] != 3'b000) rs_shamt = {1'b1, 5'd31};
    else                      rs_shamt = {1'b0, rs_lo[4:0]};
  endfunction

endpackage

// File: rtl/src2_decode.sv
// Combinational decode of the Src2 field of an instruction.
//   instr [25:0] in  : bit 25 = I, bits 11:0 = Src2
//   dec          out : operand source, shift type/amount, Rs request
module src2_decode
  import operand2_stage_pkg::*;
(
  input  logic [25:0] instr,
  output src2_t       dec
);

  // Opcode/register fields above Src2 (other than I) do not affect operand 2.
  logic unused_instr;
  assign unused_instr = ^instr[24:12];

  always_comb begin
    dec         = '0;
    dec.imm8    = instr[7:0];
    dec.rs_addr = instr[11:8];
    if (instr[25]) begin
      // Rotated immediate: rotate right by twice the 4-bit rot field.
      dec.use_imm = 1'b1;
      dec.sh      = SH_ROR;
      dec.shamt5  = {instr[11:8], 1'b0};
    end else begin
      dec.sh       = instr[6:5];
      dec.shamt5   = instr[11:7];
      dec.needs_rs = instr[4];
    end
  end

endmodule

// File: rtl/operand2_stage.sv
// Operand-2 stage: decodes Src2, optionally fetches Rs for register-specified
// shifts, and holds the shifter inputs until downstream consumes them.
//   clk, reset (sync, active low), flush (sync kill)
//   in_valid/in_ready   : upstream handshake, instr + rd2 (Rm) sampled on accept
//   rs_req/rs_addr/rs_data : one-cycle second register read of Rs
//   out_valid/out_ready : downstream handshake
//   register_o, shamt5, sh, shamt_big : shifter inputs, registered
module operand2_stage
  import operand2_stage_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [25:0]  instr,
  input  logic [N-1:0] rd2,
  output logic         rs_req,
  output logic [3:0]   rs_addr,
  input  logic [N-1:0] rs_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] register_o,
  output logic [4:0]   shamt5,
  output logic [1:0]   sh,
  output logic         shamt_big
);

  state_t         state, state_nxt;
  src2_t          dec;
  logic           accept;
  logic [N-1:0]   imm_ext;

  // Only the low byte of Rs defines the shift amount.
  logic unused_rs;
  assign unused_rs = ^rs_data;

  src2_decode u_dec (
    .instr (instr),
    .dec   (dec)
  );

  always_comb begin
    imm_ext      = '0;
    imm_ext[7:0] = dec.imm8;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      EMPTY:   in_ready = 1'b1;
      FULL:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase

    accept    = in_valid && in_ready && !flush;
    out_valid = (state == FULL);
    // Rs read is dropped on flush and while reset is held so the register
    // file never sees a request for an abandoned instruction.
    rs_req    = (state == RS_FETCH) && !flush && reset;

    if (accept)                           state_nxt = dec.needs_rs ? RS_FETCH : FULL;
    else if (state == RS_FETCH)           state_nxt = FULL;
    else if (state == FULL && out_ready)  state_nxt = EMPTY;

    if (flush) state_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Output registers only change on accept or on the Rs return, which keeps
  // them stable across downstream stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      register_o <= '0;
      shamt5     <= '0;
      sh         <= SH_LSL;
      shamt_big  <= 1'b0;
      rs_addr    <= '0;
    end else if (accept) begin
      register_o <= dec.use_imm ? imm_ext : rd2;
      sh         <= dec.sh;
      shamt5     <= dec.shamt5;
      shamt_big  <= 1'b0;
      if (dec.needs_rs) rs_addr <= dec.rs_addr;
    end else if (rs_req) begin
      {shamt_big, shamt5} <= rs_shamt(rs_data[7:0]);
    end
  end

endmodule

// File: tb/tb_operand2_stage.sv
module tb_operand2_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, rs_req, out_valid, shamt_big;
  logic [25:0] instr;
  logic [31:0] rd2, rs_data, register_o;
  logic [3:0]  rs_addr;
  logic [4:0]  shamt5;
  logic [1:0]  sh;

  logic [31:0] rf [16];
  assign rs_data = rf[rs_addr];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  operand2_stage #(.N(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .instr(instr), .rd2(rd2), .rs_req(rs_req),
    .rs_addr(rs_addr), .rs_data(rs_data), .out_valid(out_valid),
    .out_ready(out_ready), .register_o(register_o), .shamt5(shamt5),
    .sh(sh), .shamt_big(shamt_big)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ov"},    32'(out_valid),  32'd0);
    chk({tag, "_rsreq"}, 32'(rs_req),     32'd0);
    chk({tag, "_reg"},   register_o,      32'd0);
    chk({tag, "_amt"},   32'(shamt5),     32'd0);
    chk({tag, "_sh"},    32'(sh),         32'd0);
    chk({tag, "_rsa"},   32'(rs_addr),    32'd0);
    chk({tag, "_big"},   32'(shamt_big),  32'd0);
    chk({tag, "_irdy"},  32'(in_ready),   32'd1);
  endtask

  function automatic logic [25:0] f_imm(input logic [3:0] rot, input logic [7:0] imm);
    return {1'b1, 13'h1ABC, rot, imm};
  endfunction
  function automatic logic [25:0] f_sc(input logic [4:0] a, input logic [1:0] s, input logic [3:0] rm);
    return {1'b0, 13'h0F0F, a, s, 1'b0, rm};
  endfunction
  function automatic logic [25:0] f_rs(input logic [3:0] rs, input logic [1:0] s);
    return {1'b0, 13'h0000, rs, 1'b0, s, 1'b1, 4'h3};
  endfunction

  typedef struct {
    logic [25:0] instr;
    logic [31:0] rd2;
    logic [31:0] rsv;
    logic [31:0] ereg;
    logic [1:0]  esh;
    logic [4:0]  eamt;
    logic        ebig;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] reg_v;
    logic [1:0]  sh;
    logic [4:0]  amt;
    logic        big;
    logic        needs_rs;
    logic [3:0]  rs;
    int          due;
  } exp_t;

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    if (v.lat == 2) rf[v.instr[11:8]] = v.rsv;
    @(negedge clk);
    in_valid = 1'b1; instr = v.instr; rd2 = v.rd2; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; rd2 = $urandom;
    #1;
    if (v.lat == 2) begin
      chk({t, "_rsreq"},  32'(rs_req),   32'd1);
      chk({t, "_rsaddr"}, 32'(rs_addr),  32'(v.instr[11:8]));
      chk({t, "_early"},  32'(out_valid), 32'd0);
      @(negedge clk); #1;
      chk({t, "_rsonce"}, 32'(rs_req),   32'd0);
    end
    chk({t, "_ov"},  32'(out_valid), 32'd1);
    chk({t, "_reg"}, register_o,     v.ereg);
    chk({t, "_sh"},  32'(sh),        32'(v.esh));
    chk({t, "_amt"}, 32'(shamt5),    32'(v.eamt));
    chk({t, "_big"}, 32'(shamt_big), 32'(v.ebig));
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    #1 chk({t, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    vec_t vt[10];
    exp_t q[$];
    int   cyc;

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; rd2 = '0;
    for (int i = 0; i < 16; i++) rf[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1 chk_reset_vals("rst");
    reset = 1'b1;

    // Stall for three cycles then back-to-back reload
    @(negedge clk);
    in_valid = 1'b1; instr = f_imm(4'h1, 8'h5A); out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_ov",   32'(out_valid), 32'd1);
      chk("stall_reg",  register_o,     32'h0000005A);
      chk("stall_amt",  32'(shamt5),    32'd2);
      chk("stall_sh",   32'(sh),        32'd3);
      chk("stall_irdy", 32'(in_ready),  32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1; in_valid = 1'b1; instr = f_sc(5'd7, 2'b01, 4'h0); rd2 = 32'hCAFE0001;
    #1 chk("b2b_irdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("b2b_ov",  32'(out_valid), 32'd1);
    chk("b2b_reg", register_o,     32'hCAFE0001);
    chk("b2b_sh",  32'(sh),        32'd1);
    chk("b2b_amt", 32'(shamt5),    32'd7);
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;

    // Flush during RS_FETCH
    rf[9] = 32'd5;
    @(negedge clk);
    in_valid = 1'b1; instr = f_rs(4'h9, 2'b10);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1;
    #1 chk("flush_rsreq", 32'(rs_req), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_ov",   32'(out_valid), 32'd0);
    chk("flush_irdy", 32'(in_ready),  32'd1);
    @(negedge clk);
    #1 chk("flush_ov2", 32'(out_valid), 32'd0);

    // Flush suppresses a same-cycle accept
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; instr = f_imm(4'h0, 8'h11);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    #1 chk("flush_acc_ov", 32'(out_valid), 32'd0);

    // Reset while FULL (rs_addr still holds 9 from the flushed fetch)
    @(negedge clk);
    in_valid = 1'b1; instr = f_sc(5'd9, 2'b11, 4'h0); rd2 = 32'hFFFF0000;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("full_ov", 32'(out_valid), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    #1 chk_reset_vals("midrst");
    reset = 1'b1;

    // Reset while RS_FETCH abandons the read
    rf[2] = 32'd3;
    @(negedge clk);
    in_valid = 1'b1; instr = f_rs(4'h2, 2'b00);
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rsrst_ov",    32'(out_valid), 32'd0);
    chk("rsrst_rsreq", 32'(rs_req),    32'd0);
    @(negedge clk);
    #1 chk("rsrst_ov2", 32'(out_valid), 32'd0);

    // Directed vector table
    vt[0] = '{f_imm(4'h2, 8'hFF),      32'h0,        32'h0,        32'h000000FF, 2'b11, 5'd4,  1'b0, 1};
    vt[1] = '{f_sc(5'd3, 2'b10, 4'h1), 32'h80000000, 32'h0,        32'h80000000, 2'b10, 5'd3,  1'b0, 1};
    vt[2] = '{f_rs(4'h5, 2'b01),       32'h12345678, 32'h00000120, 32'h12345678, 2'b01, 5'd31, 1'b1, 2};
    vt[3] = '{f_rs(4'h7, 2'b00),       32'h0000000F, 32'hFFFFFF1F, 32'h0000000F, 2'b00, 5'd31, 1'b0, 2};
    vt[4] = '{f_rs(4'h3, 2'b10),       32'hA5A5A5A5, 32'h00000020, 32'hA5A5A5A5, 2'b10, 5'd31, 1'b1, 2};
    vt[5] = '{f_rs(4'h0, 2'b11),       32'h00000001, 32'hFFFFFF00, 32'h00000001, 2'b11, 5'd0,  1'b0, 2};
    vt[6] = '{f_imm(4'hF, 8'h00),      32'hFFFFFFFF, 32'h0,        32'h00000000, 2'b11, 5'd30, 1'b0, 1};
    vt[7] = '{f_sc(5'd0, 2'b00, 4'h2), 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 2'b00, 5'd0,  1'b0, 1};
    vt[8] = '{f_sc(5'd31, 2'b01, 4'h4),32'h00000001, 32'h0,        32'h00000001, 2'b01, 5'd31, 1'b0, 1};
    vt[9] = '{f_imm(4'h0, 8'h80),      32'h12345678, 32'h0,        32'h00000080, 2'b11, 5'd0,  1'b0, 1};
    for (int i = 0; i < 10; i++) run_vec(vt[i], i);

    // Randomized traffic against a transaction-level model: the stage holds
    // at most one operand, visible 1 or 2 cycles after acceptance.
    for (int i = 0; i < 16; i++)
      rf[i] = (i % 2 == 0) ? (($urandom & 32'hFFFFFF00) | $urandom_range(0, 40)) : $urandom;
    cyc = 0;
    for (int it = 0; it < 400; it++) begin
      logic visible, exp_rdy, exp_rsreq;
      int   form;
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      rd2       = $urandom;
      form      = $urandom_range(0, 2);
      if (form == 0)      instr = f_imm(4'($urandom), 8'($urandom));
      else if (form == 1) instr = f_sc(5'($urandom), 2'($urandom), 4'($urandom));
      else                instr = f_rs(4'($urandom), 2'($urandom));
      #1;
      visible   = (q.size() > 0) && (cyc >= q[0].due);
      exp_rsreq = (q.size() > 0) && q[0].needs_rs && (cyc == q[0].due - 1);
      chk("rnd_ov",    32'(out_valid), 32'(visible));
      chk("rnd_rsreq", 32'(rs_req),    32'(exp_rsreq));
      if (exp_rsreq) chk("rnd_rsaddr", 32'(rs_addr), 32'(q[0].rs));
      if (visible) begin
        chk("rnd_reg", register_o,     q[0].reg_v);
        chk("rnd_sh",  32'(sh),        32'(q[0].sh));
        chk("rnd_amt", 32'(shamt5),    32'(q[0].amt));
        chk("rnd_big", 32'(shamt_big), 32'(q[0].big));
      end
      exp_rdy = (q.size() == 0) ? 1'b1 : (visible ? out_ready : 1'b0);
      chk("rnd_irdy", 32'(in_ready), 32'(exp_rdy));
      if (visible && out_ready) void'(q.pop_front());
      if (in_valid && exp_rdy) begin
        exp_t e;
        e.needs_rs = 1'b0;
        e.rs       = instr[11:8];
        e.big      = 1'b0;
        e.due      = cyc + 1;
        if (form == 0) begin
          e.reg_v = 32'(instr[7:0]);
          e.sh    = 2'b11;
          e.amt   = 5'(2 * int'(instr[11:8]));
        end else begin
          e.reg_v = rd2;
          e.sh    = instr[6:5];
          if (form == 1) e.amt = instr[11:7];
          else begin
            int v;
            v          = int'(rf[instr[11:8]] % 256);
            e.needs_rs = 1'b1;
            e.due      = cyc + 2;
            if (v > 31) begin e.amt = 5'd31; e.big = 1'b1; end
            else        e.amt = 5'(v);
          end
        end
        q.push_back(e);
      end
      cyc++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
